// File: rtl/decodificador_dia_bcd.sv
// Converts an RTC BCD day byte (01..DIA_MAX) into a zero-based day index and pulses carga to preload the day counter.
// Latency: strobe sampled at edge E -> q_dia/carga valid after E+3; next byte accepted at E+4 (listo high only in IDLE).
// Backpressure: strobes while busy are dropped; `DECODIFICADOR_DIA_SOBRECARGA_EN adds a sticky sobrecarga flag for them.
module decodificador_dia_bcd #(
    parameter int DIA_MAX = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dato_bcd,
    input  logic       dato_valido,
    output logic       listo,
    output logic [4:0] q_dia,
    output logic       carga,
    output logic       error
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
    ,
    output logic       sobrecarga
`endif
);

    localparam logic [6:0] DIA_MAX_L = 7'(DIA_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } estado_t;

    estado_t     estado;
    estado_t     estado_sig;
    logic [3:0]  decenas;
    logic [3:0]  unidades;
    logic [5:0]  acc;
    logic [6:0]  valor;
    logic        byte_ok;

    // Full binary value is only needed for the range check; the datapath rebuilds it in MUL.
    assign valor   = {decenas, 3'b000} + {2'b00, decenas, 1'b0} + {3'b000, unidades};
    assign byte_ok = (decenas <= 4'd9) && (unidades <= 4'd9) &&
                     (valor != 7'd0) && (valor <= DIA_MAX_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            IDLE:    if (dato_valido) estado_sig = CHECK;
            CHECK:   estado_sig = byte_ok ? MUL : IDLE;
            MUL:     estado_sig = ADD;
            ADD:     estado_sig = DONE;
            DONE:    estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        listo = (estado == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decenas  <= 4'd0;
            unidades <= 4'd0;
            acc      <= 6'd0;
            q_dia    <= 5'd0;
            carga    <= 1'b0;
            error    <= 1'b0;
        end else begin
            unique case (estado)
                IDLE: begin
                    if (dato_valido) begin
                        decenas  <= dato_bcd[7:4];
                        unidades <= dato_bcd[3:0];
                    end
                end
                CHECK: begin
                    if (!byte_ok) begin
                        error <= 1'b1;
                    end else begin
                        acc <= {decenas[2:0], 3'b000};
                    end
                end
                MUL: begin
                    acc <= acc + {1'b0, decenas, 1'b0} + {2'b00, unidades};
                end
                ADD: begin
                    // acc is 1..DIA_MAX here, so the decrement cannot wrap.
                    q_dia <= 5'(acc - 6'd1);
                    carga <= 1'b1;
                    error <= 1'b0;
                end
                DONE: begin
                    carga <= 1'b0;
                end
                default: begin
                    carga <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sobrecarga <= 1'b0;
        end else if (dato_valido && !listo) begin
            sobrecarga <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decodificador_dia_bcd.sv
// Randomized and directed bench for decodificador_dia_bcd; two instances (DIA_MAX 31 and 30) share the stimulus.
module tb_decodificador_dia_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dato_bcd;
    logic       dato_valido;
    logic       listo_a, carga_a, error_a;
    logic       listo_b, carga_b, error_b;
    logic [4:0] q_a, q_b;
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
    logic       sobrecarga_a, sobrecarga_b;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decodificador_dia_bcd #(.DIA_MAX(31)) u_dut_a (
        .clk(clk), .reset(reset), .dato_bcd(dato_bcd), .dato_valido(dato_valido),
        .listo(listo_a), .q_dia(q_a), .carga(carga_a), .error(error_a)
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
        , .sobrecarga(sobrecarga_a)
`endif
    );

    decodificador_dia_bcd #(.DIA_MAX(30)) u_dut_b (
        .clk(clk), .reset(reset), .dato_bcd(dato_bcd), .dato_valido(dato_valido),
        .listo(listo_b), .q_dia(q_b), .carga(carga_b), .error(error_b)
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
        , .sobrecarga(sobrecarga_b)
`endif
    );

    // Reference model: expected held q_dia / error per instance.
    int dmax [2] = '{31, 30};
    int exp_q [2];
    int exp_err [2];

    // Observed outputs after edges E..E+4 of one transaction.
    logic       h_listo [2][5];
    logic       h_carga [2][5];
    logic       h_err   [2][5];
    logic [4:0] h_q     [2][5];

    function automatic int bcd_value(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b, input int mx);
        int v;
        v = bcd_value(b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (v >= 1) && (v <= mx);
    endfunction

    task automatic sample(input int k);
        h_listo[0][k] = listo_a; h_carga[0][k] = carga_a; h_err[0][k] = error_a; h_q[0][k] = q_a;
        h_listo[1][k] = listo_b; h_carga[1][k] = carga_b; h_err[1][k] = error_b; h_q[1][k] = q_b;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        dato_bcd    = b;
        dato_valido = 1'b1;
        @(posedge clk); #1;
        dato_valido = 1'b0;
        sample(0);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            sample(k);
        end
    endtask

    function automatic int carga_count(input int d);
        int n;
        n = 0;
        for (int k = 0; k < 5; k++) n += (h_carga[d][k] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    task automatic test_reset();
        dato_valido = 1'b0;
        dato_bcd    = 8'h00;
        reset       = 1'b1;
        #2 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) reset = 1'b1;
            @(posedge clk); #1;
            tests_run++;
            if ({listo_a, carga_a, error_a, q_a} !== 8'b1000_0000 ||
                {listo_b, carga_b, error_b, q_b} !== 8'b1000_0000) begin
                tests_failed++;
                $display("FAIL reset_state cycle %0d: a={listo,carga,error,q}=%b b=%b expected 10000000",
                         c, {listo_a, carga_a, error_a, q_a}, {listo_b, carga_b, error_b, q_b});
            end
        end
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
        tests_run++;
        if (sobrecarga_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sobrecarga: got %b expected 0", sobrecarga_a);
        end
`endif
        exp_q   = '{0, 0};
        exp_err = '{0, 0};
    endtask

    task automatic test_latency();
        drive_byte(8'h25);
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (h_listo[0][k] !== (k == 4) || h_carga[0][k] !== (k == 3)) begin
                tests_failed++;
                $display("FAIL latency edge E+%0d: listo=%b carga=%b expected listo=%b carga=%b",
                         k, h_listo[0][k], h_carga[0][k], (k == 4), (k == 3));
            end
        end
        tests_run++;
        if (h_q[0][3] !== 5'd24 || h_err[0][3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_value: q_dia=%0d error=%b expected 24 0", h_q[0][3], h_err[0][3]);
        end
        exp_q   = '{24, 24};
        exp_err = '{0, 0};
    endtask

    task automatic test_conversions();
        logic [7:0] dir [8] = '{8'h01, 8'h31, 8'h15, 8'h1A, 8'hA1, 8'h30, 8'h99, 8'h10};
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < 48; i++) begin
            if (i < 8) b = dir[i];
            else if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
            drive_byte(b);
            for (int d = 0; d < 2; d++) begin
                ok = bcd_ok(b, dmax[d]);
                tests_run++;
                if (h_listo[d][0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL conv_busy dut%0d byte %h: listo=%b expected 0", d, b, h_listo[d][0]);
                end
                if (ok) begin
                    exp_q[d]   = bcd_value(b) - 1;
                    exp_err[d] = 0;
                    tests_run++;
                    if (carga_count(d) != 1 || h_carga[d][3] !== 1'b1 || h_listo[d][4] !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL conv_carga dut%0d byte %h: pulses=%0d carga@E+3=%b listo@E+4=%b expected 1 1 1",
                                 d, b, carga_count(d), h_carga[d][3], h_listo[d][4]);
                    end
                    tests_run++;
                    if (h_q[d][3] !== 5'(exp_q[d]) || h_err[d][3] !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL conv_value dut%0d byte %h: q_dia=%0d error=%b expected %0d 0",
                                 d, b, h_q[d][3], h_err[d][3], exp_q[d]);
                    end
                end else begin
                    exp_err[d] = 1;
                    tests_run++;
                    if (carga_count(d) != 0 || h_err[d][1] !== 1'b1 || h_listo[d][1] !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL conv_reject dut%0d byte %h: pulses=%0d error=%b listo=%b expected 0 1 1",
                                 d, b, carga_count(d), h_err[d][1], h_listo[d][1]);
                    end
                    tests_run++;
                    if (h_q[d][4] !== 5'(exp_q[d])) begin
                        tests_failed++;
                        $display("FAIL conv_hold dut%0d byte %h: q_dia=%0d expected %0d", d, b, h_q[d][4], exp_q[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] bad [4] = '{8'h1A, 8'hA1, 8'h32, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive_byte(8'h15);
            drive_byte(bad[i]);
            tests_run++;
            if (h_err[0][1] !== 1'b1 || h_listo[0][1] !== 1'b1 || carga_count(0) != 0 || h_q[0][4] !== 5'd14) begin
                tests_failed++;
                $display("FAIL invalid %h: error=%b listo=%b pulses=%0d q_dia=%0d expected 1 1 0 14",
                         bad[i], h_err[0][1], h_listo[0][1], carga_count(0), h_q[0][4]);
            end
            drive_byte(8'h07);
            tests_run++;
            if (h_q[0][3] !== 5'd6 || h_err[0][3] !== 1'b0 || h_carga[0][3] !== 1'b1) begin
                tests_failed++;
                $display("FAIL invalid_recover after %h: q_dia=%0d error=%b carga=%b expected 6 0 1",
                         bad[i], h_q[0][3], h_err[0][3], h_carga[0][3]);
            end
        end
        exp_q   = '{6, 6};
        exp_err = '{0, 0};
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses      = 0;
        dato_bcd    = 8'h12;
        dato_valido = 1'b1;
        @(posedge clk); #1;
        dato_bcd = 8'h20;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 2) dato_valido = 1'b0;
            pulses += (carga_a === 1'b1) ? 1 : 0;
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
            tests_run++;
            if (sobrecarga_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy_sobrecarga edge E+%0d: got %b expected 1", k, sobrecarga_a);
            end
`endif
        end
        tests_run++;
        if (pulses != 1 || q_a !== 5'd11 || listo_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_drop: pulses=%0d q_dia=%0d listo=%b expected 1 11 1", pulses, q_a, listo_a);
        end
        exp_q   = '{11, 11};
        exp_err = '{0, 0};
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses      = 0;
        dato_bcd    = 8'h28;
        dato_valido = 1'b1;
        @(posedge clk); #1;
        dato_valido = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({listo_a, carga_a, error_a, q_a} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_mid_state: {listo,carga,error,q}=%b expected 10000000", {listo_a, carga_a, error_a, q_a});
        end
        repeat (2) begin
            @(posedge clk); #1;
            pulses += (carga_a === 1'b1) ? 1 : 0;
        end
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            pulses += (carga_a === 1'b1) ? 1 : 0;
        end
        tests_run++;
        if (pulses != 0 || q_a !== 5'd0 || listo_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_abort: pulses=%0d q_dia=%0d listo=%b expected 0 0 1", pulses, q_a, listo_a);
        end
`ifdef DECODIFICADOR_DIA_SOBRECARGA_EN
        tests_run++;
        if (sobrecarga_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_sobrecarga: got %b expected 0", sobrecarga_a);
        end
`endif
        drive_byte(8'h09);
        tests_run++;
        if (h_q[0][3] !== 5'd8 || h_carga[0][3] !== 1'b1 || carga_count(0) != 1 || h_listo[0][4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: q_dia=%0d carga=%b pulses=%0d listo=%b expected 8 1 1 1",
                     h_q[0][3], h_carga[0][3], carga_count(0), h_listo[0][4]);
        end
        exp_q   = '{8, 8};
        exp_err = '{0, 0};
    endtask

    initial begin
        test_reset();
        test_latency();
        test_conversions();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decodificador_dia_bcd.md
Name: decodificador_dia_bcd

Overview:
Reverse direction of the day-of-month setting counter. Accepts a two-digit BCD day byte read back from the RTC data bus, validates it, and converts it to the 5-bit zero-based day index used by the day counter (0 = day 1 … 30 = day 31). Issues a one-cycle load pulse so the counter can be preloaded with the RTC value. Conversion is a multi-cycle FSM with a ready/strobe handshake.

Parameters:
DIA_MAX, 31, highest legal day value (1..31); BCD values above it are rejected.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
dato_bcd  input  8  BCD day byte: [7:4] tens digit, [3:0] units digit
dato_valido  input  1  one-cycle strobe; dato_bcd is valid in the same cycle
listo  output  1  block idle and accepting a new byte
q_dia  output  5  zero-based day index (BCD value minus 1)
carga  output  1  one-cycle pulse; q_dia holds a newly converted value
error  output  1  last accepted byte was invalid; sticky

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, q_dia=0, carga=0, error=0, listo=1, internal capture and accumulator registers cleared.
- listo is 1 only in IDLE. It is decoded from the state register with no extra delay.
- FSM states are IDLE, CHECK, MUL, ADD and DONE.
- IDLE: on an edge E with dato_valido=1, latch tens = dato_bcd[7:4] and units = dato_bcd[3:0], then go to CHECK. With dato_valido=0, stay in IDLE.
- CHECK (edge E+1): the byte is invalid if any of these hold:
  - tens > 9 or units > 9
  - BCD value = 0
  - value > DIA_MAX
- CHECK, invalid byte: set error=1, leave q_dia unchanged, no carga, go to IDLE. listo=1 from E+1.
- CHECK, valid byte: acc = tens<<3, go to MUL.
- MUL (edge E+2): acc = acc + (tens<<1) + units, giving the binary value 1..31. Go to ADD.
- ADD (edge E+3): q_dia = acc - 1 (5-bit, never underflows since acc >= 1), carga=1, error=0. Go to DONE.
- DONE (edge E+4): carga=0, go to IDLE. listo=1 from E+4.
- Latency for a valid byte is fixed at 4 edges: strobe sampled at E gives q_dia and carga at E+3, and carga is high for exactly one cycle. The next byte can be accepted at edge E+4.
- q_dia holds its value between loads. It changes only on a valid conversion or reset.
- error clears only on the next valid conversion (same edge that sets carga) or reset.
- dato_valido while listo=0 is ignored and does not disturb the conversion in progress.
- Accumulator width is 6 bits internally; the maximum intermediate value (9*10 + 9 = 99 before range check) never reaches ADD. Only values 1..31 reach MUL.
- Reset asserted mid-conversion aborts it immediately. No carga is produced after release; the FSM restarts in IDLE.

Optional Feature:
Macro DECODIFICADOR_DIA_SOBRECARGA_EN.
- Defined: adds output port sobrecarga (1 bit, reset 0).
  - Set to 1 at any edge where dato_valido=1 and listo=0.
  - Sticky; cleared only by reset.
  - The dropped byte is still ignored.
- Not defined: no sobrecarga port and no associated logic. Strobes while busy are silently dropped.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> q_dia=0, carga=0, error=0, listo=1 throughout.
2. dato_bcd=8'h25 with one-cycle strobe at edge E:
   - listo=0 from E to E+3.
   - carga=1 for exactly the cycle after E+3, with q_dia=5'd24 and error=0.
   - listo=1 from E+4.
3. Boundaries:
   - 8'h01 -> q_dia=0.
   - 8'h31 -> q_dia=30.
   - With DIA_MAX=30, 8'h31 -> error=1 and q_dia unchanged.
4. Invalid inputs 8'h1A, 8'hA1, 8'h32, 8'h00, each after a valid 8'h15 load:
   - error=1 at E+1 and no carga.
   - q_dia stays 14, listo=1 at E+1.
   - A following valid 8'h07 -> q_dia=6, error=0.
5. Strobe 8'h12, then strobe 8'h20 at E+1 and E+2:
   - Only 8'h12 is converted (q_dia=11) and exactly one carga occurs.
   - With DECODIFICADOR_DIA_SOBRECARGA_EN, sobrecarga=1 from E+1 and stays set.
6. Strobe 8'h28 at E, then reset=0 at E+2 for 2 cycles:
   - Outputs return to reset values and no carga at any point.
   - Post-release, 8'h09 converts to q_dia=8 with normal 4-edge latency.
